// File: rtl/uart_pkg.sv
// Shared UART constants and helpers for the word assembler and its gap timer.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  // Selects which end of the word the first received byte fills.
  typedef enum logic {
    LANE_LSB_FIRST = 1'b0,
    LANE_MSB_FIRST = 1'b1
  } lane_order_e;

  function automatic int byte_count_width(input int bytes_per_word);
    return $clog2(bytes_per_word + 1);
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: reloads on every accepted byte, counts down while a
// partial word is pending and flags expiry at terminal count.
module uart_gap_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Terminal count is reached TIMEOUT_CYCLES-1 edges after the reload.
  assign expire = run && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_word_assembler.sv
// Packs received UART bytes into words with a valid/ready output stage.
// Optional inter-byte timeout is built when WORD_TIMEOUT_EN is defined.
module uart_word_assembler
  import uart_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int MSB_FIRST      = 0,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [UART_BYTE_W-1:0]                       byte_data,
  input  logic                                         byte_valid,
  input  logic                                         byte_error,
  output logic [UART_BYTE_W*BYTES_PER_WORD-1:0]        word_data,
  output logic                                         word_valid,
  input  logic                                         word_ready,
  output logic [byte_count_width(BYTES_PER_WORD)-1:0]  byte_count,
  output logic                                         overrun,
  output logic                                         frame_err,
  output logic                                         timeout
);

  localparam int CNT_W  = byte_count_width(BYTES_PER_WORD);
  localparam int WORD_W = UART_BYTE_W * BYTES_PER_WORD;
  localparam lane_order_e ORDER = (MSB_FIRST != 0) ? LANE_MSB_FIRST : LANE_LSB_FIRST;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

  if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("uart_word_assembler: illegal parameter combination");
  end

  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;

  logic              accept, err_strobe, expire;
  logic [CNT_W-1:0]  cnt_base, lane;
  logic [WORD_W-1:0] asm_base, asm_fill;
  logic              complete;

  assign accept     = byte_valid && !byte_error;
  assign err_strobe = byte_valid && byte_error;

`ifdef WORD_TIMEOUT_EN
  logic timeout_q;

  uart_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .run   (cnt_q != '0),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    // An expiring partial word is dropped first, so a byte arriving in the
    // same cycle starts a fresh word.
    cnt_base = expire ? '0 : cnt_q;
    asm_base = expire ? '0 : asm_q;
    lane     = (ORDER == LANE_MSB_FIRST) ? (LAST_IDX - cnt_base) : cnt_base;

    asm_fill = asm_base;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (lane == CNT_W'(i)) begin
        asm_fill[i*UART_BYTE_W +: UART_BYTE_W] = byte_data;
      end
    end

    complete    = accept && (cnt_base == LAST_IDX);

    cnt_d       = cnt_base;
    asm_d       = asm_base;
    word_d      = word_q;
    valid_d     = valid_q && !word_ready;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;

    if (err_strobe) begin
      cnt_d       = '0;
      asm_d       = '0;
      frame_err_d = 1'b1;
    end else if (accept) begin
      if (complete) begin
        cnt_d = '0;
        asm_d = '0;
        // Holding register frees up this cycle if the consumer accepts now.
        if (!valid_q || word_ready) begin
          word_d  = asm_fill;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_base + 1'b1;
        asm_d = asm_fill;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q       <= '0;
      word_q      <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign word_data  = word_q;
  assign word_valid = valid_q;
  assign byte_count = cnt_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed bench for uart_word_assembler: vector table plus corner sequences.
module tb_uart_word_assembler;

`ifdef WORD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        byte_error = 1'b0;
  logic        word_ready = 1'b1;

  logic [31:0] word_data;
  logic        word_valid;
  logic [2:0]  byte_count;
  logic        overrun, frame_err, timeout;

  logic [31:0] m_data;
  logic        m_valid;
  logic [2:0]  m_count;
  logic        m_overrun, m_frame_err, m_timeout;

  logic [15:0] w_data;
  logic        w_valid;
  logic [1:0]  w_count;
  logic        w_overrun, w_frame_err, w_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_word_assembler #(.BYTES_PER_WORD(4), .MSB_FIRST(0), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_error(byte_error), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .byte_count(byte_count), .overrun(overrun),
    .frame_err(frame_err), .timeout(timeout));

  uart_word_assembler #(.BYTES_PER_WORD(4), .MSB_FIRST(1), .TIMEOUT_CYCLES(16)) dut_msb (
    .clk(clk), .rst_n(rst_n), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_error(byte_error), .word_data(m_data), .word_valid(m_valid),
    .word_ready(word_ready), .byte_count(m_count), .overrun(m_overrun),
    .frame_err(m_frame_err), .timeout(m_timeout));

  uart_word_assembler #(.BYTES_PER_WORD(2), .MSB_FIRST(1), .TIMEOUT_CYCLES(16)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_error(byte_error), .word_data(w_data), .word_valid(w_valid),
    .word_ready(word_ready), .byte_count(w_count), .overrun(w_overrun),
    .frame_err(w_frame_err), .timeout(w_timeout));

  typedef struct {
    logic        v;
    logic        e;
    logic [7:0]  d;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  ec;
    logic        eo;
    logic        ef;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic e, input logic [7:0] d, input logic rdy);
    @(negedge clk);
    byte_valid = v;
    byte_error = e;
    byte_data  = d;
    word_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    byte_valid = 1'b0;
    byte_error = 1'b0;
    #1;
    chk("rst_valid", word_valid, 0);
    chk("rst_data", word_data, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_pulses", {overrun, frame_err, timeout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // v e data rdy | valid data count overrun frame_err
    vecs.push_back('{1,0,8'h11,1, 0,32'h0,       1,0,0});
    vecs.push_back('{1,0,8'h22,1, 0,32'h0,       2,0,0});
    vecs.push_back('{1,0,8'h33,1, 0,32'h0,       3,0,0});
    vecs.push_back('{1,0,8'h44,1, 1,32'h44332211,0,0,0});
    vecs.push_back('{0,0,8'h00,1, 0,32'h44332211,0,0,0});
    vecs.push_back('{1,0,8'h01,0, 0,32'h44332211,1,0,0});
    vecs.push_back('{1,0,8'h02,0, 0,32'h44332211,2,0,0});
    vecs.push_back('{1,0,8'h03,0, 0,32'h44332211,3,0,0});
    vecs.push_back('{1,0,8'h04,0, 1,32'h04030201,0,0,0});
    vecs.push_back('{1,0,8'h05,0, 1,32'h04030201,1,0,0});
    vecs.push_back('{1,0,8'h06,0, 1,32'h04030201,2,0,0});
    vecs.push_back('{1,0,8'h07,0, 1,32'h04030201,3,0,0});
    vecs.push_back('{1,0,8'h08,0, 1,32'h04030201,0,1,0});
    vecs.push_back('{0,0,8'h00,0, 1,32'h04030201,0,0,0});
    vecs.push_back('{0,0,8'h00,1, 0,32'h04030201,0,0,0});
    vecs.push_back('{0,0,8'h00,1, 0,32'h04030201,0,0,0});
    vecs.push_back('{1,0,8'hAA,1, 0,32'h04030201,1,0,0});
    vecs.push_back('{1,0,8'hBB,1, 0,32'h04030201,2,0,0});
    vecs.push_back('{1,1,8'hFF,1, 0,32'h04030201,0,0,1});
    vecs.push_back('{1,0,8'h01,1, 0,32'h04030201,1,0,0});
    vecs.push_back('{0,1,8'h77,1, 0,32'h04030201,1,0,0});
    vecs.push_back('{1,0,8'h02,1, 0,32'h04030201,2,0,0});
    vecs.push_back('{1,0,8'h03,1, 0,32'h04030201,3,0,0});
    vecs.push_back('{1,0,8'h04,1, 1,32'h04030201,0,0,0});
    vecs.push_back('{0,0,8'h00,1, 0,32'h04030201,0,0,0});
    vecs.push_back('{1,0,8'hA1,0, 0,32'h04030201,1,0,0});
    vecs.push_back('{1,0,8'hA2,0, 0,32'h04030201,2,0,0});
    vecs.push_back('{1,0,8'hA3,0, 0,32'h04030201,3,0,0});
    vecs.push_back('{1,0,8'hA4,0, 1,32'hA4A3A2A1,0,0,0});
    vecs.push_back('{1,0,8'hB1,0, 1,32'hA4A3A2A1,1,0,0});
    vecs.push_back('{1,0,8'hB2,0, 1,32'hA4A3A2A1,2,0,0});
    vecs.push_back('{1,0,8'hB3,0, 1,32'hA4A3A2A1,3,0,0});
    vecs.push_back('{1,0,8'hB4,1, 1,32'hB4B3B2B1,0,0,0});
    vecs.push_back('{1,0,8'hC1,0, 1,32'hB4B3B2B1,1,0,0});
    vecs.push_back('{1,1,8'hC2,0, 1,32'hB4B3B2B1,0,0,1});
    vecs.push_back('{0,0,8'h00,1, 0,32'hB4B3B2B1,0,0,0});

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].e, vecs[i].d, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i), word_valid, vecs[i].ev);
      chk($sformatf("vec%0d_data", i), word_data, vecs[i].ed);
      chk($sformatf("vec%0d_count", i), byte_count, vecs[i].ec);
      chk($sformatf("vec%0d_overrun", i), overrun, vecs[i].eo);
      chk($sformatf("vec%0d_frame_err", i), frame_err, vecs[i].ef);
      chk($sformatf("vec%0d_timeout", i), timeout, 0);
    end

    // MSB-first lane order, 4-byte and 2-byte words
    do_reset();
    step(1, 0, 8'h11, 1);
    step(1, 0, 8'h22, 1);
    chk("w2_valid_a", w_valid, 1);
    chk("w2_data_a", w_data, 16'h1122);
    step(1, 0, 8'h33, 1);
    step(1, 0, 8'h44, 1);
    chk("msb_valid", m_valid, 1);
    chk("msb_data", m_data, 32'h11223344);
    chk("w2_data_b", w_data, 16'h3344);
    chk("lsb_data_same_bytes", word_data, 32'h44332211);
    do_reset();
    step(1, 0, 8'hAB, 1);
    chk("w2_count_mid", w_count, 1);
    step(1, 0, 8'hCD, 1);
    chk("w2_valid_c", w_valid, 1);
    chk("w2_data_c", w_data, 16'hABCD);

    // Inter-byte timeout
    do_reset();
    step(1, 0, 8'h55, 1);
    chk("to_count_start", byte_count, 1);
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 8'h00, 1);
      chk($sformatf("to_pulse_k%0d", k), timeout, (TO_EN && k == 16));
      if (k == 16) chk("to_count_k16", byte_count, TO_EN ? 0 : 1);
    end
    step(1, 0, 8'h01, 1);
    step(1, 0, 8'h02, 1);
    step(1, 0, 8'h03, 1);
    chk("to_valid_3", word_valid, !TO_EN);
    if (!TO_EN) chk("to_data_nomacro", word_data, 32'h03020155);
    step(1, 0, 8'h04, 1);
    chk("to_valid_4", word_valid, TO_EN);
    chk("to_count_4", byte_count, TO_EN ? 0 : 1);
    if (TO_EN) chk("to_data_macro", word_data, 32'h04030201);

`ifdef WORD_TIMEOUT_EN
    // Byte arriving in the expiry cycle starts a new word
    do_reset();
    step(1, 0, 8'h99, 1);
    for (int k = 1; k <= 15; k++) step(0, 0, 8'h00, 1);
    step(1, 0, 8'h01, 1);
    chk("to_same_cycle_pulse", timeout, 1);
    chk("to_same_cycle_count", byte_count, 1);
    step(1, 0, 8'h02, 1);
    step(1, 0, 8'h03, 1);
    step(1, 0, 8'h04, 1);
    chk("to_same_cycle_data", word_data, 32'h04030201);
`endif

    // Asynchronous reset in the middle of a word with a word held
    do_reset();
    step(1, 0, 8'h01, 0);
    step(1, 0, 8'h02, 0);
    step(1, 0, 8'h03, 0);
    step(1, 0, 8'h04, 0);
    step(1, 0, 8'h05, 0);
    step(1, 0, 8'h06, 0);
    step(1, 0, 8'h07, 0);
    chk("pre_rst_valid", word_valid, 1);
    chk("pre_rst_count", byte_count, 3);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", word_valid, 0);
    chk("async_rst_data", word_data, 0);
    chk("async_rst_count", byte_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 8'h11, 1);
    step(1, 0, 8'h22, 1);
    step(1, 0, 8'h33, 1);
    step(1, 0, 8'h44, 1);
    chk("post_rst_valid", word_valid, 1);
    chk("post_rst_data", word_data, 32'h44332211);
    chk("post_rst_overrun", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_word_assembler.md
Name: uart_word_assembler

Overview:
- Packs bytes from the UART byte receiver into words of BYTES_PER_WORD bytes; sits between the byte receiver and the word-consuming command/data logic.
- Fully synchronous to clk; byte_valid is sampled as a level each cycle, never used as a clock.
- Adds over the previous word packer: configurable width and byte order, valid/ready output handshake with a one-word holding register, error-driven resynchronisation, overrun detection and optional inter-byte timeout.

Parameters:
- BYTES_PER_WORD, 4, bytes per output word; legal range 2..8.
- MSB_FIRST, 0, 0: first received byte lands in word_data[7:0]; 1: first received byte lands in the top byte.
- TIMEOUT_CYCLES, 100000, clk cycles allowed between bytes of one word (used only with WORD_TIMEOUT_EN); must be >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- byte_data  input  8  received byte, valid when byte_valid=1
- byte_valid  input  1  one-cycle strobe, byte available
- byte_error  input  1  framing error reported with the strobe, qualified by byte_valid
- word_data  output  8*BYTES_PER_WORD  assembled word, stable while word_valid=1
- word_valid  output  1  word available; held until accepted
- word_ready  input  1  consumer accepts the word when word_valid&&word_ready
- byte_count  output  $clog2(BYTES_PER_WORD+1)  bytes in the partial word, 0..BYTES_PER_WORD-1
- overrun  output  1  one-cycle pulse: a completed word was dropped
- frame_err  output  1  one-cycle pulse: a byte_error discarded the partial word
- timeout  output  1  one-cycle pulse: partial word discarded by timeout (constant 0 without macro)

Behaviour:
- Reset (async assert, sync release): word_data=0, word_valid=0, byte_count=0, overrun=0, frame_err=0, timeout=0, assembly register=0, timeout counter=0.
- Byte acceptance, when byte_valid=1 and byte_error=0:
  - MSB_FIRST=0: byte is written at lane byte_count.
  - MSB_FIRST=1: byte is written at lane BYTES_PER_WORD-1-byte_count.
  - byte_count increments.
- Completion: when the accepted byte is number BYTES_PER_WORD, the full word (including that byte) moves to the output register on the same edge.
  - word_valid rises the next cycle, i.e. latency of 1 clk from the final byte strobe.
  - byte_count returns to 0 and the assembly register clears.
- Handshake: word_valid stays 1 and word_data stays frozen until a cycle with word_ready=1; word_valid drops on the following edge.
  - Same-cycle accept and new completion: the new word loads and word_valid stays 1. No bubble, no overrun.
- Overrun: a completion while word_valid=1 and word_ready=0:
  - the new word is discarded and the held word is kept;
  - overrun pulses for one cycle;
  - byte_count still returns to 0.
- Byte error: byte_valid=1 with byte_error=1:
  - the byte is dropped, the partial word is cleared and byte_count goes to 0;
  - frame_err pulses;
  - a word already held in the output register is unaffected.
- byte_error without byte_valid is ignored.
- Partial bytes never leak to word_data; the output register changes only on completion.
- Reset mid-word discards everything immediately and asynchronously.

Optional Feature:
- Macro: WORD_TIMEOUT_EN.
- Defined:
  - A counter runs while byte_count!=0 and clears on each accepted byte.
  - When it reaches TIMEOUT_CYCLES, the partial word is cleared, byte_count goes to 0 and timeout pulses one cycle.
  - A byte arriving in the same cycle as expiry is treated as the first byte of a new word.
  - The counter is idle while byte_count=0.
- Undefined: no counter is built, timeout is tied to 0 and partial words wait indefinitely.

Decomposition:
- Shared package uart_pkg holds:
  - the constant UART_BYTE_W=8;
  - a function that returns the byte_count width for a given BYTES_PER_WORD;
  - a localparam-style enum for the lane-order selection.
- One natural sub-module, uart_gap_timer: the inter-byte timeout counter, instantiated only under WORD_TIMEOUT_EN.
- The assembly and output registers stay in the top module.

Test Plan:
- Defaults, word_ready=1, send 0x11,0x22,0x33,0x44 -> one word_valid pulse one cycle after the 4th strobe, word_data=0x44332211.
- MSB_FIRST=1, same bytes -> word_data=0x11223344; with BYTES_PER_WORD=2, bytes 0xAB,0xCD -> 0xABCD.
- word_ready=0, send 8 bytes 0x01..0x08 -> word_data held at 0x04030201, overrun pulses once after byte 8; raising ready gives one accept and word_valid=0 next cycle.
- Send 0xAA,0xBB, then a strobe with byte_error=1, then 0x01..0x04 -> frame_err pulses, byte_count=0 after the error, word_data=0x04030201.
- WORD_TIMEOUT_EN, TIMEOUT_CYCLES=16: send 0x55, wait 20 cycles -> timeout pulses at cycle 16; next 4 bytes 0x01..0x04 form 0x04030201. Without the macro, the same stimulus gives timeout=0 and word_data=0x03020155.
- Assert rst_n after 3 bytes -> all outputs 0 immediately; the next 4 bytes form a clean word.
